mem_port_arbiter: RTL and testbench

- Shares the single-port data memory (d_mem) between two requesters: the pipeline MEM stage (port P) and a debug/DMA loader (port D).
- Fixed priority to P, with a starvation counter that forces a D grant after STARVE_MAX consecutive losses.
- Sits between the MEM stage and the write-back/data-memory wrapper.
- Tags in-flight reads so that read data returns to the requester that issued it, and generates a pipeline stall.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_rd_tag_pipe.sv | 38 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Brief    : Shared types and constants for the data-memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_D = 1'b1
  } mem_owner_t;

  typedef struct packed {
    logic       vld;
    mem_owner_t own;
  } rd_tag_t;

  localparam int STARVE_MAX_DEF = 4;
  // Wide enough for the largest legal STARVE_MAX (15).
  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// ============================================================================
//  Module   : mem_port_arbiter_rd_tag_pipe
//  Brief    : DEPTH-stage shift register of read tags, sync active-low clear.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter_rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Fixed-priority (P) data-memory arbiter with D starvation guard
//             and tagged read return.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] c_starve_lim = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_cnt_q;
  logic [CNT_W-1:0]  starve_cnt_d;
  logic [DATA_W-1:0] p_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic    d_win;
  logic    win_we;
  logic    any_gnt;
  rd_tag_t tag_in;
  rd_tag_t tag_out;

  // D takes the port when alone, or when it has lost STARVE_MAX times in a row.
  always_comb begin
    d_win = 1'b0;
    if (d_req && (!p_req || (starve_cnt_q == c_starve_lim))) begin
      d_win = 1'b1;
    end
  end

  assign p_gnt   = rst & p_req & ~d_win;
  assign d_gnt   = rst & d_req &  d_win;
  assign p_stall = p_req & ~p_gnt;
  assign any_gnt = p_gnt | d_gnt;

  assign mem_addr  = d_win ? d_addr  : p_addr;
  assign mem_wdata = d_win ? d_wdata : p_wdata;
  assign win_we    = d_win ? d_we    : p_we;
  assign mem_write = any_gnt &  win_we;
  assign mem_read  = any_gnt & ~win_we;

  always_comb begin
    starve_cnt_d = '0;
    if (d_req && !d_gnt) begin
      starve_cnt_d = sat_inc(starve_cnt_q, c_starve_lim);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = mem_read;
    tag_in.own = d_win ? OWN_D : OWN_P;
  end

  mem_port_arbiter_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Gating with rst drops a return that would land during the reset cycle.
  assign p_rvalid = rst & tag_out.vld & (tag_out.own == OWN_P);
  assign d_rvalid = rst & tag_out.vld & (tag_out.own == OWN_D);

  // d_mem presents data in the return cycle: forward it, then hold it.
  assign p_rdata = p_rvalid ? mem_rdata : p_rdata_q;
  assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (p_rvalid) begin
        p_rdata_q <= mem_rdata;
      end
      if (d_rvalid) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed self-checking bench for mem_port_arbiter with a
//             one-cycle-latency d_mem model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_gnt;
  logic              p_rvalid;
  logic [DATA_W-1:0] p_rdata;
  logic              p_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [256];

  int n_chk;
  int n_err;

  mem_port_arbiter #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (4),
    .RD_LAT     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_req     (p_req),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_gnt     (p_gnt),
    .p_rvalid  (p_rvalid),
    .p_rdata   (p_rdata),
    .p_stall   (p_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d_mem model: write at the edge, registered read data one cycle later.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata     <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem_rdata = '0;
    rst = 1'b0;
    p_req = 1'b1; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset held three cycles with both requesting.
    for (int c = 0; c < 3; c++) begin
      step();
      sample();
      check("rst_p_gnt",   32'(p_gnt),     32'd0);
      check("rst_d_gnt",   32'(d_gnt),     32'd0);
      check("rst_mem_rd",  32'(mem_read),  32'd0);
      check("rst_mem_wr",  32'(mem_write), 32'd0);
      check("rst_p_rvld",  32'(p_rvalid),  32'd0);
      check("rst_d_rvld",  32'(d_rvalid),  32'd0);
    end
    check("rst_cnt",     32'(dut.starve_cnt_q), 32'd0);
    check("rst_p_rdata", p_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);

    // P write 0xDEADBEEF to addr 5, then read it back.
    step();
    rst = 1'b1; d_req = 1'b0;
    p_req = 1'b1; p_we = 1'b1; p_addr = 8'd5; p_wdata = 32'hDEADBEEF;
    sample();
    check("pw_gnt",   32'(p_gnt),     32'd1);
    check("pw_write", 32'(mem_write), 32'd1);
    check("pw_read",  32'(mem_read),  32'd0);
    check("pw_addr",  32'(mem_addr),  32'd5);
    check("pw_wdata", mem_wdata,      32'hDEADBEEF);
    step();
    p_we = 1'b0;
    sample();
    check("pr_gnt",   32'(p_gnt),    32'd1);
    check("pr_read",  32'(mem_read), 32'd1);
    check("pw_norv",  32'(p_rvalid), 32'd0);
    step();
    p_req = 1'b0;
    sample();
    check("pr_rvld",  32'(p_rvalid), 32'd1);
    check("pr_rdata", p_rdata,       32'hDEADBEEF);
    check("pr_drvld", 32'(d_rvalid), 32'd0);
    check("idle_rd",  32'(mem_read),  32'd0);
    step();
    sample();
    check("pr_pulse", 32'(p_rvalid), 32'd0);
    check("pr_hold",  p_rdata,       32'hDEADBEEF);

    // D preloads addr 1 = 0x11, addr 2 = 0x22.
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd1; d_wdata = 32'h11;
    sample();
    check("dw_gnt",   32'(d_gnt),     32'd1);
    check("dw_write", 32'(mem_write), 32'd1);
    check("dw_wdata", mem_wdata,      32'h11);
    step();
    d_addr = 8'd2; d_wdata = 32'h22;
    sample();
    check("dw2_addr", 32'(mem_addr), 32'd2);

    // Interleaved: P reads addr 1, D reads addr 2 the next cycle.
    step();
    d_req = 1'b0; d_we = 1'b0;
    p_req = 1'b1; p_we = 1'b0; p_addr = 8'd1;
    sample();
    check("il_p_gnt", 32'(p_gnt), 32'd1);
    step();
    p_req = 1'b0;
    d_req = 1'b1; d_addr = 8'd2;
    sample();
    check("il_d_gnt",  32'(d_gnt),    32'd1);
    check("il_p_rvld", 32'(p_rvalid), 32'd1);
    check("il_p_data", p_rdata,       32'h11);
    check("il_d_none", 32'(d_rvalid), 32'd0);
    step();
    d_req = 1'b0;
    sample();
    check("il_d_rvld", 32'(d_rvalid), 32'd1);
    check("il_d_data", d_rdata,       32'h22);
    check("il_p_none", 32'(p_rvalid), 32'd0);
    check("il_p_hold", p_rdata,       32'h11);

    // Starvation: both request reads for six cycles.
    p_addr = 8'd1; d_addr = 8'd2;
    for (int c = 0; c < 6; c++) begin
      step();
      p_req = 1'b1; d_req = 1'b1;
      sample();
      check($sformatf("sv_p_gnt%0d", c), 32'(p_gnt),   (c != 4) ? 32'd1 : 32'd0);
      check($sformatf("sv_d_gnt%0d", c), 32'(d_gnt),   (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("sv_stall%0d", c), 32'(p_stall), (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("sv_cnt%0d", c),   32'(dut.starve_cnt_q), (c <= 4) ? 32'(c) : 32'd0);
      check($sformatf("sv_prv%0d", c),   32'(p_rvalid), (c >= 1 && c != 5) ? 32'd1 : 32'd0);
      check($sformatf("sv_drv%0d", c),   32'(d_rvalid), (c == 5) ? 32'd1 : 32'd0);
    end
    check("sv_d_data", d_rdata, 32'h22);
    step();
    p_req = 1'b0; d_req = 1'b0;
    sample();
    check("sv_last_rv", 32'(p_rvalid), 32'd1);
    check("sv_last_d",  p_rdata,       32'h11);

    // D alone for six cycles.
    for (int c = 0; c < 6; c++) begin
      step();
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'd2;
      sample();
      check($sformatf("do_gnt%0d", c),   32'(d_gnt),   32'd1);
      check($sformatf("do_stall%0d", c), 32'(p_stall), 32'd0);
      check($sformatf("do_cnt%0d", c),   32'(dut.starve_cnt_q), 32'd0);
    end

    // Reset mid-flight drops the pending D read.
    step();
    d_req = 1'b0;
    sample();
    step();
    d_req = 1'b1; d_addr = 8'd2;
    sample();
    check("mr_gnt", 32'(d_gnt), 32'd1);
    step();
    rst = 1'b0; d_req = 1'b0;
    sample();
    check("mr_drop", 32'(d_rvalid), 32'd0);
    step();
    rst = 1'b1;
    sample();
    check("mr_drop2", 32'(d_rvalid), 32'd0);
    check("mr_clr",   d_rdata,       32'd0);
    step();
    d_req = 1'b1; d_addr = 8'd1;
    sample();
    check("mr_gnt2", 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0;
    sample();
    check("mr_rvld", 32'(d_rvalid), 32'd1);
    check("mr_data", d_rdata,       32'h11);
    check("mr_prv",  32'(p_rvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
